// File: rtl/dds_pkg.sv
// Shared constants and types for the DDS key controller: tuning-word step
// table, clamp bounds, waveform and FSM encodings.
package dds_pkg;

    localparam logic [31:0] FTW_MIN      = 32'd86;
    localparam logic [31:0] FTW_MAX      = 32'd858993459;
    localparam logic [2:0]  STEP_IDX_RST = 3'd3;
    localparam logic [2:0]  STEP_IDX_MAX = 3'd5;

    typedef enum logic [1:0] {
        WaveSine     = 2'd0,
        WaveSquare   = 2'd1,
        WaveTriangle = 2'd2,
        WaveSaw      = 2'd3
    } wave_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StSend = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        OpWave  = 3'd0,
        OpStep  = 3'd1,
        OpUp    = 3'd2,
        OpDown  = 3'd3,
        OpCombo = 3'd4
    } op_e;

    // Tuning-word increment for each step index, 1 Hz .. 100 kHz at 50 MHz.
    function automatic logic [31:0] step_of(input logic [2:0] idx);
        logic [31:0] val;
        case (idx)
            3'd0:    val = 32'd86;
            3'd1:    val = 32'd859;
            3'd2:    val = 32'd8590;
            3'd3:    val = 32'd85899;
            3'd4:    val = 32'd858993;
            3'd5:    val = 32'd8589935;
            default: val = 32'd86;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/ftw_sat_addsub.sv
// Combinational saturating add/subtract of tuning words, clamped to [lo, hi].
module ftw_sat_addsub #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    input  logic [W-1:0] lo,
    input  logic [W-1:0] hi,
    output logic [W-1:0] y
);

    // One extra bit so neither the sum nor the lower bound test can wrap.
    logic [W:0] sum;
    logic [W:0] sub_floor;

    assign sum       = {1'b0, a} + {1'b0, b};
    assign sub_floor = {1'b0, b} + {1'b0, lo};

    // Select the clamped result for the requested direction.
    always_comb begin
        y = a;
        if (!sub) begin
            y = (sum > {1'b0, hi}) ? hi : sum[W-1:0];
        end else begin
            y = ({1'b0, a} < sub_floor) ? lo : (a - b);
        end
    end

endmodule

// File: rtl/dds_key_ctrl.sv
// Key-driven configuration controller for a DDS core. Key presses are latched
// into pending flags, serviced one per IDLE -> CALC -> SEND pass, and offered
// to the core with a valid/ready handshake.
// Optional build macro DDS_KEY_COMBO_RESET_EN: up+down pending together
// restores the default tuning word and step in a single transaction.
module dds_key_ctrl
    import dds_pkg::*;
#(
    parameter int unsigned      FTW_W       = 32,
    parameter logic [FTW_W-1:0] FTW_DEFAULT = 32'd85899
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_wave_p,
    input  logic             key_up_p,
    input  logic             key_down_p,
    input  logic             key_step_p,
    input  logic             cfg_ready,
    output logic             cfg_valid,
    output logic [1:0]       wave_sel,
    output logic [FTW_W-1:0] ftw,
    output logic [2:0]       step_idx
);

    // Pending flag bit positions.
    localparam int unsigned PWave = 0;
    localparam int unsigned PStep = 1;
    localparam int unsigned PUp   = 2;
    localparam int unsigned PDown = 3;

    state_e           state_q;
    op_e              op_q;
    op_e              op_sel;
    logic [3:0]       pend_q;
    logic [3:0]       pend_clr;
    logic [3:0]       clr_eff;
    logic [3:0]       key_pulses;
    wave_e            wave_q;
    logic [2:0]       step_q;
    logic [FTW_W-1:0] ftw_q;
    logic [FTW_W-1:0] ftw_calc;
    logic             valid_q;

    assign key_pulses = {key_down_p, key_up_p, key_step_p, key_wave_p};

    // Pick the highest-priority pending request and the flags it consumes.
    always_comb begin
        op_sel   = OpWave;
        pend_clr = '0;
        if (pend_q[PWave]) begin
            op_sel          = OpWave;
            pend_clr[PWave] = 1'b1;
        end else if (pend_q[PStep]) begin
            op_sel          = OpStep;
            pend_clr[PStep] = 1'b1;
`ifdef DDS_KEY_COMBO_RESET_EN
        end else if (pend_q[PUp] && pend_q[PDown]) begin
            op_sel          = OpCombo;
            pend_clr[PUp]   = 1'b1;
            pend_clr[PDown] = 1'b1;
`endif
        end else if (pend_q[PUp]) begin
            op_sel        = OpUp;
            pend_clr[PUp] = 1'b1;
        end else if (pend_q[PDown]) begin
            op_sel          = OpDown;
            pend_clr[PDown] = 1'b1;
        end
    end

    // Flags are only consumed when IDLE actually dispatches a request.
    assign clr_eff = (state_q == StIdle) ? pend_clr : 4'b0000;

    ftw_sat_addsub #(
        .W (FTW_W)
    ) u_sat (
        .a   (ftw_q),
        .b   (FTW_W'(step_of(step_q))),
        .sub (op_q == OpDown),
        .lo  (FTW_W'(FTW_MIN)),
        .hi  (FTW_W'(FTW_MAX)),
        .y   (ftw_calc)
    );

    // Controller FSM with pending flags and registered configuration outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            op_q    <= OpWave;
            pend_q  <= '0;
            valid_q <= 1'b0;
            wave_q  <= WaveSine;
            step_q  <= STEP_IDX_RST;
            ftw_q   <= FTW_DEFAULT;
        end else begin
            // A press landing in the service cycle re-arms its flag.
            pend_q <= (pend_q & ~clr_eff) | key_pulses;
            case (state_q)
                StIdle: begin
                    if (|pend_q) begin
                        op_q    <= op_sel;
                        state_q <= StCalc;
                    end
                end
                StCalc: begin
                    case (op_q)
                        OpWave: wave_q <= wave_e'(wave_q + 2'd1);
                        OpStep: step_q <= (step_q == STEP_IDX_MAX) ? 3'd0 : step_q + 3'd1;
                        OpUp,
                        OpDown: ftw_q <= ftw_calc;
                        OpCombo: begin
                            ftw_q  <= FTW_DEFAULT;
                            step_q <= STEP_IDX_RST;
                        end
                        default: ;
                    endcase
                    // Offered even when saturation left the word unchanged.
                    valid_q <= 1'b1;
                    state_q <= StSend;
                end
                StSend: begin
                    if (cfg_ready) begin
                        valid_q <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign cfg_valid = valid_q;
    assign wave_sel  = wave_q;
    assign ftw       = ftw_q;
    assign step_idx  = step_q;

endmodule

// File: doc/dds_key_ctrl.md
DDS_KEY_CTRL -- requirements
Module: dds_key_ctrl

Interface
REQ-001 SHALL have parameter FTW_W, default 32, meaning frequency tuning word width.
REQ-002 SHALL have parameter FTW_DEFAULT, default 32'd85899, meaning reset tuning word (1 kHz at 50 MHz).
REQ-003 SHALL have ports: clk  input  1  system clock, 50 MHz.
REQ-004 SHALL have ports: rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports: key_wave_p, key_up_p, key_down_p, key_step_p  input  1 each  one-cycle press pulses from the debounce stage.
REQ-006 SHALL have ports: cfg_ready  input  1  DDS core accepts configuration.
REQ-007 SHALL have ports: cfg_valid  output  1  configuration offered to the DDS core.
REQ-008 SHALL have ports: wave_sel  output  2  0 sine, 1 square, 2 triangle, 3 sawtooth.
REQ-009 SHALL have ports: ftw  output  FTW_W  phase increment.
REQ-010 SHALL have ports: step_idx  output  3  current step index, range 0..5.

Function
REQ-011 SHALL register each key pulse into its own pending flag on the edge that samples it; a set flag SHALL absorb repeat pulses; flags SHALL be cleared only when serviced.
REQ-012 SHALL implement the FSM IDLE -> CALC -> SEND -> IDLE.
- IDLE: any flag set -> CALC, servicing the highest-priority flag in the order wave > step > up > down, and clearing that flag.
- CALC: compute and register the new output values -> SEND.
REQ-013 SHALL assert cfg_valid in SEND only, and hold wave_sel, ftw and step_idx stable while cfg_valid=1; SEND -> IDLE on cfg_valid and cfg_ready.
REQ-014 SHALL raise cfg_valid at the 2nd rising edge after the edge that samples a pulse, when in IDLE with no other flags pending.
REQ-015 SHALL update wave_sel as wave_sel+1 modulo 4.
REQ-016 SHALL update step_idx as step_idx+1, wrapping 5 -> 0.
REQ-017 SHALL update ftw as ftw+STEP[step_idx], saturating at FTW_MAX.
REQ-018 SHALL update ftw as ftw-STEP[step_idx], saturating at FTW_MIN; no wrap in either direction.
REQ-019 SHALL still enter SEND even when a saturated operation leaves ftw unchanged.
REQ-020 SHALL record pulses arriving during CALC or SEND in their flags; they are serviced afterwards.
REQ-021 SHALL service each flag set in the same cycle across successive passes, in priority order.
REQ-022 SHALL accept cfg_ready asserted outside SEND and ignore it.

Reset
REQ-023 SHALL, on rst=1 at a clock edge, set state IDLE, all flags 0, cfg_valid 0, wave_sel 0, step_idx 3, ftw FTW_DEFAULT.
REQ-024 SHALL, on reset mid-SEND, drop the pending transaction with cfg_valid=0 on the next cycle.
REQ-025 SHALL have rst take precedence over any pulse in the same cycle.

Configuration
REQ-026 SHALL provide macro DDS_KEY_COMBO_RESET_EN.
- Defined: when up and down flags are both set on entry to IDLE, SHALL clear both and load ftw=FTW_DEFAULT, step_idx=3 via CALC/SEND as one transaction.
- Undefined: up and down SHALL be serviced separately in priority order.

Structure
REQ-027 SHALL take constants from shared package dds_pkg:
- STEP table: 86, 859, 8590, 85899, 858993, 8589935 (1 Hz..100 kHz).
- FTW_MIN=86 and FTW_MAX=858993459 (10 MHz).
- Waveform enum and FSM state enum.
REQ-028 SHALL use one sub-module, ftw_sat_addsub: combinational saturating add/subtract of FTW_W-bit operands with clamp bounds.

Verification
REQ-029 SHALL cover: reset, then one key_up_p pulse with cfg_ready=1 -> cfg_valid 2 edges later, ftw=171798, step_idx=3.
REQ-030 SHALL cover: ftw=858900000, step_idx=5, key_up_p -> ftw=858993459; second key_up_p -> ftw unchanged and cfg_valid still asserted.
REQ-031 SHALL cover: key_wave_p four times -> wave_sel 1, 2, 3, 0; key_step_p six times from reset -> step_idx 4, 5, 0, 1, 2, 3.
REQ-032 SHALL cover: cfg_ready=0 for 10 cycles in SEND with 3 key_up_p pulses arriving -> outputs stable; after ready, exactly one further up transaction.
REQ-033 SHALL cover: key_wave_p and key_down_p in the same cycle -> wave transaction first, then down; with DDS_KEY_COMBO_RESET_EN, up+down together -> ftw=85899.
REQ-034 SHALL cover: rst asserted while cfg_valid=1 -> next cycle cfg_valid=0, ftw=85899, wave_sel=0, step_idx=3.
